// File: rtl/seq_signed_mult.sv
// Iterative radix-2 shift-add multiplier, one multiplier bit per cycle.
// tc selects unsigned (0) or two's-complement (1) operands per transaction.
module seq_signed_mult #(
  parameter int A_WIDTH       = 8,
  parameter int B_WIDTH       = 8,
  parameter int PRODUCT_WIDTH = A_WIDTH + B_WIDTH,
  parameter int CNT_WIDTH     = $clog2(B_WIDTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [A_WIDTH-1:0]       dat_a,
  input  logic [B_WIDTH-1:0]       dat_b,
  input  logic                     tc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PRODUCT_WIDTH-1:0] product,
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(B_WIDTH - 1);

  state_t                   state_r;
  state_t                   state_s;
  logic [CNT_WIDTH-1:0]     cnt_r;
  logic [PRODUCT_WIDTH-1:0] acc_r;
  logic [PRODUCT_WIDTH-1:0] mag_a_r;
  logic [B_WIDTH-1:0]       mag_b_r;
  logic                     neg_r;
  logic [PRODUCT_WIDTH-1:0] product_r;
  logic                     out_valid_r;

  logic                     accept_s;
  logic                     last_s;
  logic                     take_s;
  logic [A_WIDTH-1:0]       abs_a_s;
  logic [B_WIDTH-1:0]       abs_b_s;

  assign in_ready  = (state_r == IDLE);
  assign busy      = (state_r != IDLE);
  assign out_valid = out_valid_r;
  assign product   = product_r;

  assign accept_s = in_valid & in_ready;
  assign last_s   = (cnt_r == CNT_LAST);
  assign take_s   = out_valid_r & out_ready;

  // Operand magnitudes; the most-negative value wraps to itself, which is the correct unsigned magnitude.
  always_comb begin
    abs_a_s = (tc & dat_a[A_WIDTH-1]) ? ({A_WIDTH{1'b0}} - dat_a) : dat_a;
    abs_b_s = (tc & dat_b[B_WIDTH-1]) ? ({B_WIDTH{1'b0}} - dat_b) : dat_b;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = CALC;
        else          state_s = IDLE;
      end
      CALC: begin
        if (last_s) state_s = SIGN;
        else        state_s = CALC;
      end
      SIGN: state_s = DONE;
      DONE: begin
        if (take_s) state_s = IDLE;
        else        state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Datapath: multiplicand shifts left and multiplier shifts right, so bit 0 of mag_b_r is always the current bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r       <= {CNT_WIDTH{1'b0}};
      acc_r       <= {PRODUCT_WIDTH{1'b0}};
      mag_a_r     <= {PRODUCT_WIDTH{1'b0}};
      mag_b_r     <= {B_WIDTH{1'b0}};
      neg_r       <= 1'b0;
      product_r   <= {PRODUCT_WIDTH{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            mag_a_r <= {{(PRODUCT_WIDTH-A_WIDTH){1'b0}}, abs_a_s};
            mag_b_r <= abs_b_s;
            neg_r   <= tc & (dat_a[A_WIDTH-1] ^ dat_b[B_WIDTH-1]);
            acc_r   <= {PRODUCT_WIDTH{1'b0}};
            cnt_r   <= {CNT_WIDTH{1'b0}};
          end
        end
        CALC: begin
          if (mag_b_r[0]) begin
            acc_r <= acc_r + mag_a_r;
          end
          mag_a_r <= mag_a_r << 1;
          mag_b_r <= mag_b_r >> 1;
          cnt_r   <= cnt_r + CNT_ONE;
        end
        SIGN: begin
          product_r   <= neg_r ? ({PRODUCT_WIDTH{1'b0}} - acc_r) : acc_r;
          out_valid_r <= 1'b1;
        end
        DONE: begin
          if (take_s) begin
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_signed_mult.sv
// Directed and randomised self-checking bench for seq_signed_mult (default 8x8).
module tb_seq_signed_mult;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  dat_a;
  logic [7:0]  dat_b;
  logic        tc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        busy;

  int total;
  int bad;

  seq_signed_mult dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dat_a     (dat_a),
    .dat_b     (dat_b),
    .tc        (tc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one operand set for a single edge (caller guarantees IDLE).
  task automatic accept_op(input logic t, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    tc = t; dat_a = a; dat_b = b; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dat_a = 8'h00; dat_b = 8'h00; tc = 1'b0;
  endtask

  // Accept an operation and wait (bounded) for out_valid; lat=0 means it never came.
  task automatic run_op(input logic t, input logic [7:0] a, input logic [7:0] b,
                        output int lat, output logic [15:0] prod, output logic ready_hi);
    accept_op(t, a, b);
    lat = 0;
    ready_hi = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (in_ready) ready_hi = 1'b1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    prod = product;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (product !== 16'h0000) begin bad++; $display("FAIL reset_product: got %h want 0000", product); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_unsigned_max;
    int lat; logic [15:0] p; logic rh;
    out_ready = 1'b1;
    run_op(1'b0, 8'hFF, 8'hFF, lat, p, rh);
    total++; if (lat !== 9) begin bad++; $display("FAIL umax_latency: got %0d want 9", lat); end
    total++; if (p !== 16'hFE01) begin bad++; $display("FAIL umax_product: got %h want fe01", p); end
    total++; if (rh !== 1'b0) begin bad++; $display("FAIL umax_in_ready_low: got %b want 0", rh); end
    @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL umax_release: got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready);
    end
  endtask

  task automatic test_modes;
    int lat; logic [15:0] p; logic rh;
    out_ready = 1'b1;
    run_op(1'b1, 8'hFD, 8'h05, lat, p, rh);
    total++; if (p !== 16'hFFF1 || lat !== 9) begin bad++; $display("FAIL signed_m3x5: got %h lat %0d want fff1 lat 9", p, lat); end
    @(posedge clk); #1;
    run_op(1'b0, 8'hFD, 8'h05, lat, p, rh);
    total++; if (p !== 16'h04F1 || lat !== 9) begin bad++; $display("FAIL unsigned_253x5: got %h lat %0d want 04f1 lat 9", p, lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_most_negative;
    int lat; logic [15:0] p; logic rh;
    out_ready = 1'b1;
    run_op(1'b1, 8'h80, 8'h80, lat, p, rh);
    total++; if (p !== 16'h4000) begin bad++; $display("FAIL mostneg_sq: got %h want 4000", p); end
    @(posedge clk); #1;
    run_op(1'b1, 8'h80, 8'h7F, lat, p, rh);
    total++; if (p !== 16'hC080) begin bad++; $display("FAIL mostneg_x127: got %h want c080", p); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    int lat; logic [15:0] p; logic rh; int errs;
    out_ready = 1'b0;
    run_op(1'b0, 8'd12, 8'd10, lat, p, rh);
    total++; if (p !== 16'h0078 || lat !== 9) begin bad++; $display("FAIL bp_product: got %h lat %0d want 0078 lat 9", p, lat); end
    @(negedge clk);
    in_valid = 1'b1; dat_a = 8'd3; dat_b = 8'd3; tc = 1'b0;
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || product !== 16'h0078 || in_ready !== 1'b0) errs++;
    end
    total++; if (errs != 0) begin bad++; $display("FAIL bp_hold: got %0d unstable cycles want 0", errs); end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL bp_release: got ov=%b ir=%b busy=%b want 0 1 0", out_valid, in_ready, busy);
    end
    total++; if (product !== 16'h0078) begin bad++; $display("FAIL bp_product_kept: got %h want 0078", product); end
  endtask

  task automatic test_reset_mid_op;
    int lat; logic [15:0] p; logic rh; logic seen;
    out_ready = 1'b1;
    accept_op(1'b0, 8'd7, 8'd9);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    total++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || product !== 16'h0000) begin
      bad++; $display("FAIL midreset_outputs: got ir=%b busy=%b ov=%b p=%h want 1 0 0 0000", in_ready, busy, out_valid, product);
    end
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL midreset_no_valid: got %b want 0", seen); end
    run_op(1'b0, 8'd2, 8'd3, lat, p, rh);
    total++; if (p !== 16'h0006 || lat !== 9) begin bad++; $display("FAIL midreset_next: got %h lat %0d want 0006 lat 9", p, lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_sign;
    int lat; logic [15:0] p; logic rh;
    out_ready = 1'b1;
    run_op(1'b1, 8'h00, 8'h81, lat, p, rh);
    total++; if (p !== 16'h0000) begin bad++; $display("FAIL zero_sign: got %h want 0000", p); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int lat; logic [15:0] p; logic rh;
    logic [7:0] a; logic [7:0] b; logic t;
    int sa; int sb; int full; logic [15:0] expv;
    out_ready = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      t = 1'($urandom_range(0, 1));
      sa = t ? int'($signed(a)) : int'(a);
      sb = t ? int'($signed(b)) : int'(b);
      full = sa * sb;
      expv = full[15:0];
      run_op(t, a, b, lat, p, rh);
      total++; if (p !== expv || lat !== 9) begin
        bad++; $display("FAIL b2b_%0d: tc=%b a=%h b=%h got %h lat %0d want %h lat 9", n, t, a, b, p, lat, expv);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; in_valid = 1'b0; dat_a = 8'h00; dat_b = 8'h00; tc = 1'b0; out_ready = 1'b0;
    test_reset;
    test_unsigned_max;
    test_modes;
    test_most_negative;
    test_backpressure;
    test_reset_mid_op;
    test_zero_sign;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
